// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding and
// the ARF / IR control constants driven towards ALU_System.
package fetch_defs;

  typedef enum logic [2:0] {
    CLR     = 3'd0,
    FETCH_L = 3'd1,
    FETCH_H = 3'd2,
    ISSUE   = 3'd3,
    EXEC    = 3'd4,
    HALTED  = 3'd5
  } state_t;

  localparam logic [1:0] FUN_HOLD  = 2'b00;
  localparam logic [1:0] FUN_INC   = 2'b01;
  localparam logic [1:0] FUN_LOAD  = 2'b10;
  localparam logic [1:0] FUN_CLR   = 2'b11;

  localparam logic [1:0] IR_LOAD   = 2'b10;
  localparam logic [3:0] REGSEL_PC = 4'b1000;
  localparam logic [1:0] OUTD_PC   = 2'b00;

  function automatic logic is_fetch(input state_t s);
    return (s == FETCH_L) || (s == FETCH_H);
  endfunction

endpackage

// File: rtl/fetch_sequencer_seq_timing_counter.sv
// Step counter behind timing_signal: synchronous load, saturating increment
// and a terminal-count flag at TMAX.
module seq_timing_counter #(
  parameter logic [3:0] TMAX = 4'd15
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       inc,
  output logic [3:0] count,
  output logic       tc
);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != TMAX)) begin
      count <= count + 4'd1;
    end
  end

  assign tc = (count == TMAX);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/sequence stage: clears PC, reads each 16-bit instruction as two bytes
// into IR, issues the opcode to execute and times the execute phase.
module fetch_sequencer
  import fetch_defs::*;
#(
  parameter logic [3:0] TMAX = 4'd15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic        Ins_Ready,
  input  logic        Exec_Done,
  input  logic        Halt,
  output logic        Mem_CS,
  output logic        Mem_WR,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RegSel,
  output logic        IR_Enable,
  output logic        IR_LH,
  output logic [1:0]  IR_Funsel,
  output logic        Ins_Valid,
  output logic [3:0]  Ins_Opcode,
  output logic [3:0]  timing_signal,
  output logic        Fetch_Busy,
  output logic        Seq_Error,
  output state_t      dbg_state
);

  state_t     state, state_nxt;
  logic       clr_armed;
  logic       halt_pend;
  logic       ts_tc;
  logic       ts_load, ts_inc;
  logic [3:0] ts_load_val;
  logic       fetch_nxt;
  logic       unused_ir;

  assign unused_ir   = ^IROut[11:0];
  assign Mem_WR      = 1'b0;
  assign ARF_OutDSel = OUTD_PC;
  assign dbg_state   = state;
  assign fetch_nxt   = is_fetch(state_nxt);

  // Handshake: Ins_Valid is high for every ISSUE cycle with Ins_Opcode held
  // stable; the transfer happens on the rising edge where Ins_Valid and
  // Ins_Ready are both high, and Ins_Ready is ignored in every other state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      CLR:     state_nxt = clr_armed ? FETCH_L : CLR;
      FETCH_L: state_nxt = FETCH_H;
      FETCH_H: state_nxt = ISSUE;
      ISSUE:   if (Ins_Ready) state_nxt = EXEC;
      EXEC: begin
        if (Exec_Done)  state_nxt = (halt_pend || Halt) ? HALTED : FETCH_L;
        else if (ts_tc) state_nxt = FETCH_L;
      end
      HALTED:  if (!Halt) state_nxt = FETCH_L;
      default: state_nxt = CLR;
    endcase
  end

  always_comb begin
    ts_inc  = (state == EXEC) && (state_nxt == EXEC);
    ts_load = !ts_inc;
    unique case (state_nxt)
      FETCH_H: ts_load_val = 4'd1;
      ISSUE:   ts_load_val = 4'd2;
      EXEC:    ts_load_val = 4'd3;
      default: ts_load_val = 4'd0;
    endcase
  end

  seq_timing_counter #(.TMAX(TMAX)) u_timing (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (ts_load),
    .load_val (ts_load_val),
    .inc      (ts_inc),
    .count    (timing_signal),
    .tc       (ts_tc)
  );

  // Outputs are registered from the next state. The reset cycle itself shows
  // idle controls, so CLR holds one clocked cycle to drive the PC clear.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= CLR;
      clr_armed  <= 1'b0;
      halt_pend  <= 1'b0;
      Mem_CS     <= 1'b1;
      IR_Enable  <= 1'b0;
      IR_LH      <= 1'b0;
      IR_Funsel  <= 2'b00;
      ARF_RegSel <= 4'b0000;
      ARF_FunSel <= FUN_HOLD;
      Ins_Valid  <= 1'b0;
      Ins_Opcode <= 4'h0;
      Fetch_Busy <= 1'b1;
      Seq_Error  <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_armed  <= 1'b1;
      Mem_CS     <= !fetch_nxt;
      IR_Enable  <= fetch_nxt;
      IR_LH      <= (state_nxt == FETCH_H);
      IR_Funsel  <= fetch_nxt ? IR_LOAD : 2'b00;
      ARF_RegSel <= (fetch_nxt || (state_nxt == CLR)) ? REGSEL_PC : 4'b0000;
      ARF_FunSel <= (state_nxt == CLR) ? FUN_CLR : (fetch_nxt ? FUN_INC : FUN_HOLD);
      Ins_Valid  <= (state_nxt == ISSUE);
      Fetch_Busy <= fetch_nxt || (state_nxt == CLR);
      if ((state_nxt == ISSUE) && (state != ISSUE)) begin
        Ins_Opcode <= IROut[15:12];
      end
      if ((state == EXEC) && !Exec_Done && ts_tc) begin
        Seq_Error <= 1'b1;
      end
      // HALTED consumes the request and watches Halt directly, so a level
      // held through HALTED does not re-arm a halt for the next instruction.
      if ((state == HALTED) || (state_nxt == HALTED)) begin
        halt_pend <= 1'b0;
      end else if (Halt) begin
        halt_pend <= 1'b1;
      end
    end
  end

endmodule
